// File: rtl/lock_ramp_gen.sv
// rtl/lock_ramp_gen.sv - triangle/sawtooth scan ramp generator for the lock controller
// Optional build macro: LOCK_RAMP_SAWTOOTH_EN adds the ramp_sawtooth input.
module lock_ramp_gen (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ramp_enable,
  input  logic               ramp_reset,
  input  logic [31:0]        ramp_step,
  input  logic signed [13:0] low_lim,
  input  logic signed [13:0] high_lim,
`ifdef LOCK_RAMP_SAWTOOTH_EN
  input  logic               ramp_sawtooth,
`endif
  output logic signed [13:0] ramp_out,
  output logic               ramp_trigger,
  output logic               ramp_dir,
  output logic               ramp_busy
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

  state_t             state, state_n;
  logic signed [31:0] acc, acc_n;
  logic               dir_n, trig_n;
  logic               saw;
  logic               lim_ok;
  logic               go_up;
  logic signed [32:0] acc_x, sum, diff, hi_x, lo_x, step_x;

`ifdef LOCK_RAMP_SAWTOOTH_EN
  assign saw = ramp_sawtooth;
`else
  assign saw = 1'b0;
`endif

  // 33-bit working values so that neither the step nor the limit compare can wrap
  assign acc_x  = {acc[31], acc};
  assign step_x = {1'b0, ramp_step};
  assign hi_x   = {high_lim[13], high_lim, 18'b0};
  assign lo_x   = {low_lim[13], low_lim, 18'b0};
  assign sum    = acc_x + step_x;
  assign diff   = acc_x - step_x;
  assign lim_ok = low_lim < high_lim;

  assign ramp_out  = acc[31:18];
  assign ramp_busy = (state == UP) || (state == DOWN);

  // State, accumulator, direction and trigger registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      acc          <= '0;
      ramp_dir     <= 1'b1;
      ramp_trigger <= 1'b0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      ramp_dir     <= dir_n;
      ramp_trigger <= trig_n;
    end
  end

  // Next-state and next-accumulator decision; HOLD resumes along the stored direction
  always_comb begin
    state_n = state;
    acc_n   = acc;
    dir_n   = ramp_dir;
    trig_n  = 1'b0;
    go_up   = (state == HOLD) ? ramp_dir : (state == UP);
    if (ramp_reset || !lim_ok) begin
      state_n = IDLE;
      acc_n   = lo_x[31:0];
      dir_n   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          acc_n = lo_x[31:0];
          dir_n = 1'b1;
          if (ramp_enable) begin
            state_n = UP;
            trig_n  = 1'b1;
          end
        end
        default: begin
          if (!ramp_enable) begin
            state_n = HOLD;
          end else if (acc_x > hi_x) begin
            // limits moved below the current value: clamp and turn (or restart in sawtooth)
            if (saw) begin
              acc_n   = lo_x[31:0];
              state_n = UP;
              dir_n   = 1'b1;
              trig_n  = 1'b1;
            end else begin
              acc_n   = hi_x[31:0];
              state_n = DOWN;
              dir_n   = 1'b0;
            end
          end else if (acc_x < lo_x) begin
            acc_n   = lo_x[31:0];
            state_n = UP;
            dir_n   = 1'b1;
            trig_n  = 1'b1;
          end else if (ramp_step == 32'd0) begin
            state_n = go_up ? UP : DOWN;
          end else if (go_up) begin
            if (saw && (acc_x == hi_x)) begin
              acc_n   = lo_x[31:0];
              state_n = UP;
              trig_n  = 1'b1;
            end else if (sum >= hi_x) begin
              acc_n   = hi_x[31:0];
              state_n = saw ? UP : DOWN;
              dir_n   = saw;
            end else begin
              acc_n   = sum[31:0];
              state_n = UP;
            end
          end else begin
            if (diff <= lo_x) begin
              acc_n   = lo_x[31:0];
              state_n = UP;
              dir_n   = 1'b1;
              trig_n  = 1'b1;
            end else begin
              acc_n   = diff[31:0];
              state_n = DOWN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ramp_gen.sv
// tb/tb_lock_ramp_gen.sv - self-checking bench for lock_ramp_gen
module tb_lock_ramp_gen;

  logic               clk;
  logic               rstn;
  logic               ramp_enable;
  logic               ramp_reset;
  logic [31:0]        ramp_step;
  logic signed [13:0] low_lim;
  logic signed [13:0] high_lim;
  logic               ramp_sawtooth;
  logic signed [13:0] ramp_out;
  logic               ramp_trigger;
  logic               ramp_dir;
  logic               ramp_busy;

  int n_total = 0;
  int n_pass  = 0;

  lock_ramp_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .ramp_enable  (ramp_enable),
    .ramp_reset   (ramp_reset),
    .ramp_step    (ramp_step),
    .low_lim      (low_lim),
    .high_lim     (high_lim),
`ifdef LOCK_RAMP_SAWTOOTH_EN
    .ramp_sawtooth(ramp_sawtooth),
`endif
    .ramp_out     (ramp_out),
    .ramp_trigger (ramp_trigger),
    .ramp_dir     (ramp_dir),
    .ramp_busy    (ramp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          rs;
    logic [31:0] step;
    int          lo;
    int          hi;
    int          out;
    bit          trig;
    bit          dir;
    bit          busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string name, input int out, input bit trig, input bit dir, input bit busy);
    chk({name, " ramp_out"}, int'(ramp_out), out);
    chk({name, " ramp_trigger"}, int'(ramp_trigger), int'(trig));
    chk({name, " ramp_dir"}, int'(ramp_dir), int'(dir));
    chk({name, " ramp_busy"}, int'(ramp_busy), int'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] S1  = 32'h0004_0000;
  localparam logic [31:0] S2  = 32'h0008_0000;
  localparam logic [31:0] S12 = 32'h0030_0000;

  initial begin
    int pos, e_out;
    bit e_dir;

    // en rs step lo hi | out trig dir busy
    vecs.push_back('{0, 0, S2,   -3, 3,  -3, 0, 1, 0}); // IDLE loads low limit
    vecs.push_back('{1, 0, S2,   -3, 3,  -3, 1, 1, 1}); // start, trigger
    vecs.push_back('{1, 0, S2,   -3, 3,  -1, 0, 1, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,   1, 0, 1, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,   3, 0, 0, 1}); // clamp high, turn
    vecs.push_back('{1, 0, S2,   -3, 3,   1, 0, 0, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,  -1, 0, 0, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,  -3, 1, 1, 1}); // clamp low, trigger
    vecs.push_back('{1, 0, S2,   -3, 3,  -1, 0, 1, 1});
    vecs.push_back('{0, 0, S2,   -3, 3,  -1, 0, 1, 0}); // hold
    vecs.push_back('{0, 0, S2,   -3, 3,  -1, 0, 1, 0});
    vecs.push_back('{1, 0, S2,   -3, 3,   1, 0, 1, 1}); // resume up
    vecs.push_back('{1, 0, S2,   -3, 3,   3, 0, 0, 1});
    vecs.push_back('{0, 0, S2,   -3, 3,   3, 0, 0, 0}); // hold while descending
    vecs.push_back('{1, 0, S2,   -3, 3,   1, 0, 0, 1}); // resume down
    vecs.push_back('{1, 1, S2,   -3, 3,  -3, 0, 1, 0}); // ramp_reset beats enable
    vecs.push_back('{1, 0, S2,   -3, 3,  -3, 1, 1, 1});
    vecs.push_back('{1, 0, 32'd0,-3, 3,  -3, 0, 1, 1}); // zero step
    vecs.push_back('{1, 0, 32'd0,-3, 3,  -3, 0, 1, 1});
    vecs.push_back('{1, 0, S12,  -3, 3,   3, 0, 0, 1}); // big step clamps at high
    vecs.push_back('{1, 0, S12,  -3, 3,  -3, 1, 1, 1}); // and at low
    vecs.push_back('{1, 0, S2,   -3, 3,  -1, 0, 1, 1});
    vecs.push_back('{1, 0, S2,    5, 3,   5, 0, 1, 0}); // inverted limits force IDLE
    vecs.push_back('{1, 0, S2,   -3, 3,  -3, 1, 1, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,  -1, 0, 1, 1});
    vecs.push_back('{1, 0, S2,   -3, 3,   1, 0, 1, 1});
    vecs.push_back('{1, 0, S2,   -3, 0,   0, 0, 0, 1}); // high lowered below acc
    vecs.push_back('{1, 0, S2,   -3, 0,  -2, 0, 0, 1});
    vecs.push_back('{1, 0, S2,   -1, 0,  -1, 1, 1, 1}); // low raised above acc
    vecs.push_back('{1, 0, S2,   -1, 0,   0, 0, 0, 1});

    rstn = 1'b0; ramp_enable = 1'b0; ramp_reset = 1'b0; ramp_step = S2;
    low_lim = -14'sd3; high_lim = 14'sd3; ramp_sawtooth = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 0, 1, 0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      ramp_enable = vecs[i].en;
      ramp_reset  = vecs[i].rs;
      ramp_step   = vecs[i].step;
      low_lim     = 14'(vecs[i].lo);
      high_lim    = 14'(vecs[i].hi);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].trig, vecs[i].dir, vecs[i].busy);
    end

    // full triangle -100..100..-100 at 1 LSB per cycle
    ramp_reset = 1'b1; ramp_enable = 1'b1; ramp_step = S1;
    low_lim = -14'sd100; high_lim = 14'sd100;
    tick();
    chk_all("restart idle", -100, 0, 1, 0);
    ramp_reset = 1'b0;
    for (int k = 0; k <= 937; k++) begin
      tick();
      pos   = k % 400;
      e_out = (pos <= 200) ? (-100 + pos) : (100 - (pos - 200));
      e_dir = (pos < 200);
      chk($sformatf("tri out k=%0d", k), int'(ramp_out), e_out);
      chk($sformatf("tri trig k=%0d", k), int'(ramp_trigger), (pos == 0) ? 1 : 0);
      chk($sformatf("tri dir k=%0d", k), int'(ramp_dir), int'(e_dir));
    end

    // freeze at 37 ascending for 50 cycles
    ramp_enable = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk_all($sformatf("hold k=%0d", k), 37, 0, 1, 0);
    end
    ramp_enable = 1'b1;
    tick();
    chk_all("resume", 38, 0, 1, 1);
    repeat (22) tick();
    chk("reach 60", int'(ramp_out), 60);
    high_lim = 14'sd20;
    tick();
    chk_all("high drop", 20, 0, 0, 1);

    // asynchronous reset mid-cycle
    #2;
    rstn = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 1, 0);
    tick();
    rstn = 1'b1;

`ifdef LOCK_RAMP_SAWTOOTH_EN
    ramp_sawtooth = 1'b1; ramp_step = S2; low_lim = -14'sd3; high_lim = 14'sd3;
    tick(); chk_all("saw start", -3, 1, 1, 1);
    tick(); chk_all("saw s1", -1, 0, 1, 1);
    tick(); chk_all("saw s2", 1, 0, 1, 1);
    tick(); chk_all("saw top", 3, 0, 1, 1);
    tick(); chk_all("saw wrap", -3, 1, 1, 1);
    tick(); chk_all("saw s3", -1, 0, 1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lock_ramp_gen.md
LOCK_RAMP_GEN -- requirements
Module: lock_ramp_gen

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ramp_enable  input  1  run/freeze control, driven by lock controller ramp_enable output.
REQ-004 SHALL have port: ramp_reset  input  1  synchronous restart request, level-sensitive.
REQ-005 SHALL have port: ramp_step  input  32  unsigned increment per cycle, Q14.18 (LSB = 2^-18 output LSB).
REQ-006 SHALL have port: low_lim  input  14  signed lower ramp bound.
REQ-007 SHALL have port: high_lim  input  14  signed upper ramp bound.
REQ-008 SHALL have port: ramp_out  output  14  signed registered ramp value, feeds PID sum stage.
REQ-009 SHALL have port: ramp_trigger  output  1  one-cycle pulse at every period start, feeds lock controller time counter.
REQ-010 SHALL have port: ramp_dir  output  1  1 = ascending, 0 = descending.
REQ-011 SHALL have port: ramp_busy  output  1  high in UP or DOWN state.

Function
REQ-012 SHALL hold a 32-bit signed accumulator acc (14 integer, 18 fraction bits); ramp_out = acc[31:18], registered, no extra latency.
REQ-013 SHALL compute acc +/- ramp_step in 33 bits; limit compares use 33-bit values of {lim, 18'b0}; no wrap-around permitted.
REQ-014 SHALL implement states IDLE, UP, DOWN, HOLD.
REQ-015 IDLE: acc = {low_lim,18'b0}, ramp_dir = 1; -> UP when ramp_enable = 1, ramp_reset = 0 and low_lim < high_lim, with ramp_trigger pulsed on the transition cycle.
REQ-016 UP: acc += ramp_step; if sum >= {high_lim,18'b0}, acc clamps to high limit and state -> DOWN in same cycle.
REQ-017 DOWN: acc -= ramp_step; if difference <= {low_lim,18'b0}, acc clamps to low limit, state -> UP and ramp_trigger pulses in same cycle.
REQ-018 UP/DOWN with ramp_enable = 0 -> HOLD; acc frozen; ramp_dir keeps last direction.
REQ-019 HOLD with ramp_enable = 1 -> resumes stored direction next cycle; no ramp_trigger pulse.
REQ-020 ramp_reset = 1 SHALL force IDLE from any state next cycle, taking priority over ramp_enable.
REQ-021 low_lim >= high_lim SHALL force IDLE from any state; ramp_out = low_lim; no ramp_trigger.
REQ-022 ramp_step = 0 in UP/DOWN: acc constant, no trigger, state unchanged.
REQ-023 Limits changed mid-run leaving acc outside window: clamp to the violated limit on next active cycle and apply REQ-016/017 turn rules.
REQ-024 ramp_trigger SHALL never be high two consecutive cycles unless a full period is exactly one cycle.

Reset
REQ-025 rstn = 0 SHALL immediately set state IDLE, acc = 0, ramp_out = 0, ramp_trigger = 0, ramp_dir = 1, ramp_busy = 0.
REQ-026 Reset mid-ramp SHALL discard HOLD direction; first cycle after release behaves as IDLE.

Configuration
REQ-027 Macro LOCK_RAMP_SAWTOOTH_EN defined: extra input ramp_sawtooth (1 bit); when 1, reaching high limit SHALL reload acc = {low_lim,18'b0}, stay UP and pulse ramp_trigger; DOWN never entered.
REQ-028 Macro undefined: port absent; triangle behaviour only per REQ-016/017.

Verification
REQ-029 low_lim=-100, high_lim=100, ramp_step=0x00040000, enable=1 -> ramp_out -100..100..-100 by 1 LSB/cycle, ramp_trigger every 400 cycles.
REQ-030 Same setup, enable=0 at ramp_out=37 ascending for 50 cycles -> ramp_out stays 37, ramp_busy=0; re-enable -> 38 next cycle, no trigger.
REQ-031 ramp_step=0x00300000 (12 LSB), high_lim=100 -> values clamp exactly at 100 and -100, no overshoot.
REQ-032 ramp_reset pulse mid-descent at 50 -> IDLE, ramp_out=-100, then trigger pulse and ascent restart.
REQ-033 high_lim set to 20 while ramp_out=60 ascending -> next cycle ramp_out=20, ramp_dir=0.
REQ-034 rstn asserted mid-ramp -> all outputs zero without clock edge; LOCK_RAMP_SAWTOOTH_EN build with ramp_sawtooth=1 -> 100 followed by -100 with trigger.
